// File: rtl/debug_io_pkg.sv
// Shared types and constants for the debug/coprocessor IO sequencer.
// Optional CSR support is selected in the top with DEBUG_IO_CSR_EN.
package debug_io_pkg;

    typedef enum logic [1:0] {
        OP_READ_GPR  = 2'd0,
        OP_WRITE_GPR = 2'd1,
        OP_READ_CSR  = 2'd2,
        OP_WRITE_CSR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HALT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int CTL_WE   = 0;
    localparam int CTL_RD   = 1;
    localparam int CTL_CSR  = 3;
    localparam int CTL_HALT = 4;
    localparam int CTLW     = 5;

    localparam int GPR_AW = 5;
    localparam int CSR_AW = 12;
    localparam int AW     = 15;

    function automatic logic op_is_write(input op_e op);
        return (op == OP_WRITE_GPR) || (op == OP_WRITE_CSR);
    endfunction

    function automatic logic op_is_csr(input op_e op);
        return (op == OP_READ_CSR) || (op == OP_WRITE_CSR);
    endfunction

endpackage

// File: rtl/debug_io_if.sv
// Command/response link plus the datapath coprocessor IO port.
// master = sequencer side, slave = debug link and datapath side.
interface debug_io_if #(
    parameter int N = 64
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [14:0]   cmd_addr;
    logic [N-1:0]  cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_rdata;
    logic          rsp_err;
    logic          mem_busy;
    logic [14:0]   coprocessorIOAddr;
    logic [4:0]    coprocessorIOControl;
    logic [N-1:0]  coprocessorIODataOut;
    logic [N-1:0]  coprocessorIODataIn;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
               mem_busy, coprocessorIODataIn,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               coprocessorIOAddr, coprocessorIOControl, coprocessorIODataOut
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
               mem_busy, coprocessorIODataIn,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               coprocessorIOAddr, coprocessorIOControl, coprocessorIODataOut
    );
endinterface

// File: rtl/debug_io_timer.sv
// Saturating wait counter for memory quiescence; reached flags the
// increment that brings the count to TIMEOUT.
module debug_io_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic reached
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    // Wait counter: clear wins, increment saturates at TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (inc && (count_r != CW'(TIMEOUT))) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign reached = inc && (count_r >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/debug_io_sequencer.sv
// Debug/coprocessor access sequencer: halts fetch, waits for memory to drain,
// performs one GPR/CSR access. CSR ops exist only with DEBUG_IO_CSR_EN defined.
module debug_io_sequencer
    import debug_io_pkg::*;
#(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    debug_io_if.master io
);

`ifdef DEBUG_IO_CSR_EN
    localparam int LAT_AW = CSR_AW;
`else
    localparam int LAT_AW = GPR_AW;
`endif
    localparam logic [CTLW-1:0] CTL_HALT_ONLY = 5'b1_0000;

    state_e             state_r;
    logic               wr_r;
`ifdef DEBUG_IO_CSR_EN
    logic               csr_r;
`endif
    logic [LAT_AW-1:0]  addr_r;
    logic [N-1:0]       wdata_r;

    logic               cmd_ready_r;
    logic               rsp_valid_r;
    logic               rsp_err_r;
    logic [N-1:0]       rsp_rdata_r;
    logic [AW-1:0]      cop_addr_r;
    logic [CTLW-1:0]    cop_ctl_r;
    logic [N-1:0]       cop_dout_r;

    logic               cmd_ok_s;
    logic               acc_csr_s;
    logic [AW-1:0]      acc_addr_s;
    logic [CTLW-1:0]    acc_ctl_s;
    logic               timer_clr_s;
    logic               timer_inc_s;
    logic               timeout_s;

    // Command validity: address must fit the field width of its target.
    always_comb begin
        case (op_e'(io.cmd_op))
            OP_READ_GPR, OP_WRITE_GPR: cmd_ok_s = (io.cmd_addr[14:5] == 10'd0);
`ifdef DEBUG_IO_CSR_EN
            OP_READ_CSR, OP_WRITE_CSR: cmd_ok_s = (io.cmd_addr[14:12] == 3'd0);
`endif
            default:                   cmd_ok_s = 1'b0;
        endcase
    end

    // Address and control for the access cycle, from the latched command.
    always_comb begin
        acc_csr_s = 1'b0;
`ifdef DEBUG_IO_CSR_EN
        acc_csr_s = csr_r;
`endif
        acc_ctl_s          = CTL_HALT_ONLY;
        acc_ctl_s[CTL_WE]  = wr_r;
        acc_ctl_s[CTL_RD]  = ~wr_r;
        acc_ctl_s[CTL_CSR] = acc_csr_s;
        if (acc_csr_s) begin
            acc_addr_s = AW'(addr_r);
        end else begin
            acc_addr_s = AW'(addr_r[GPR_AW-1:0]);
        end
    end

    assign timer_clr_s = (state_r != ST_HALT);
    assign timer_inc_s = (state_r == ST_HALT) && io.mem_busy;

    debug_io_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr_s),
        .inc     (timer_inc_s),
        .reached (timeout_s)
    );

    // Sequencer FSM; every output is a register updated on the transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            wr_r        <= 1'b0;
`ifdef DEBUG_IO_CSR_EN
            csr_r       <= 1'b0;
`endif
            addr_r      <= {LAT_AW{1'b0}};
            wdata_r     <= {N{1'b0}};
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {N{1'b0}};
            cop_addr_r  <= {AW{1'b0}};
            cop_ctl_r   <= {CTLW{1'b0}};
            cop_dout_r  <= {N{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (io.cmd_valid && cmd_ready_r) begin
                        wr_r        <= op_is_write(op_e'(io.cmd_op));
`ifdef DEBUG_IO_CSR_EN
                        csr_r       <= op_is_csr(op_e'(io.cmd_op));
`endif
                        addr_r      <= io.cmd_addr[LAT_AW-1:0];
                        wdata_r     <= io.cmd_wdata;
                        cmd_ready_r <= 1'b0;
                        if (cmd_ok_s) begin
                            state_r   <= ST_HALT;
                            cop_ctl_r <= CTL_HALT_ONLY;
                        end else begin
                            // Rejected commands answer at once and never halt the core.
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (!io.mem_busy) begin
                        state_r    <= ST_ACCESS;
                        cop_addr_r <= acc_addr_s;
                        cop_ctl_r  <= acc_ctl_s;
                        cop_dout_r <= wr_r ? wdata_r : {N{1'b0}};
                    end else if (timeout_s) begin
                        state_r     <= ST_RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                ST_ACCESS: begin
                    state_r     <= ST_RESP;
                    cop_addr_r  <= {AW{1'b0}};
                    cop_ctl_r   <= CTL_HALT_ONLY;
                    cop_dout_r  <= {N{1'b0}};
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= wr_r ? {N{1'b0}} : io.coprocessorIODataIn;
                end
                ST_RESP: begin
                    if (io.rsp_ready) begin
                        state_r     <= ST_IDLE;
                        cmd_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        rsp_rdata_r <= {N{1'b0}};
                        cop_ctl_r   <= {CTLW{1'b0}};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    rsp_err_r   <= 1'b0;
                    rsp_rdata_r <= {N{1'b0}};
                    cop_addr_r  <= {AW{1'b0}};
                    cop_ctl_r   <= {CTLW{1'b0}};
                    cop_dout_r  <= {N{1'b0}};
                end
            endcase
        end
    end

    assign io.cmd_ready            = cmd_ready_r;
    assign io.rsp_valid            = rsp_valid_r;
    assign io.rsp_err              = rsp_err_r;
    assign io.rsp_rdata            = rsp_rdata_r;
    assign io.coprocessorIOAddr    = cop_addr_r;
    assign io.coprocessorIOControl = cop_ctl_r;
    assign io.coprocessorIODataOut = cop_dout_r;

endmodule

// File: tb/tb_debug_io_sequencer.sv
// Bench for debug_io_sequencer: directed table, random commands against a
// timeline model, and asynchronous reset during HALT and RESP.
module tb_debug_io_sequencer;
    import debug_io_pkg::*;

    localparam int N  = 64;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    debug_io_if #(.N(N)) io ();

    debug_io_sequencer #(.N(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    typedef struct {
        logic [1:0]  op;
        logic [14:0] addr;
        logic [63:0] wdata;
        int          busy_n;
        logic [63:0] datain;
        int          stall;
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          exp_rsp;
        int          exp_acc;
        logic [4:0]  exp_ctl;
        logic [14:0] exp_addr;
        logic [63:0] exp_dout;
        logic        exp_halt;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic vec_t mk(input logic [1:0] op, input logic [14:0] addr,
                                input logic [63:0] wdata, input int busy_n,
                                input logic [63:0] datain, input int stall,
                                input logic err, input logic [63:0] rdata,
                                input int rsp, input int acc, input logic [4:0] ctl,
                                input logic [14:0] eaddr, input logic [63:0] dout,
                                input logic halt);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.busy_n = busy_n;
        v.datain = datain; v.stall = stall; v.exp_err = err; v.exp_rdata = rdata;
        v.exp_rsp = rsp; v.exp_acc = acc; v.exp_ctl = ctl; v.exp_addr = eaddr;
        v.exp_dout = dout; v.exp_halt = halt;
        return v;
    endfunction

    // Timeline model: which cycle (after acceptance) sees the access and the response.
    function automatic vec_t ref_model(input logic [1:0] op, input logic [14:0] addr,
                                       input logic [63:0] wdata, input int busy_n,
                                       input logic [63:0] datain, input int stall);
        vec_t v;
        bit csr_en, is_csr, is_wr, ok;
`ifdef DEBUG_IO_CSR_EN
        csr_en = 1'b1;
`else
        csr_en = 1'b0;
`endif
        is_csr = (op == OP_READ_CSR) || (op == OP_WRITE_CSR);
        is_wr  = (op == OP_WRITE_GPR) || (op == OP_WRITE_CSR);
        ok     = is_csr ? (csr_en && (addr >> 12) == 0) : ((addr >> 5) == 0);
        v = mk(op, addr, wdata, busy_n, datain, stall,
               1'b0, 64'd0, 0, 0, 5'd0, 15'd0, 64'd0, 1'b0);
        if (!ok) begin
            v.exp_err = 1'b1;
            v.exp_rsp = 1;
        end else if (busy_n >= TO) begin
            v.exp_err  = 1'b1;
            v.exp_rsp  = TO + 1;
            v.exp_halt = 1'b1;
        end else begin
            v.exp_halt  = 1'b1;
            v.exp_acc   = busy_n + 2;
            v.exp_rsp   = busy_n + 3;
            v.exp_ctl   = 5'(16 + (is_wr ? 1 : 2) + (is_csr ? 8 : 0));
            v.exp_addr  = is_csr ? (addr % 15'd4096) : (addr % 15'd32);
            v.exp_dout  = is_wr ? wdata : 64'd0;
            v.exp_rdata = is_wr ? 64'd0 : datain;
        end
        return v;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_cmd_ready"}, 64'(io.cmd_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(io.rsp_valid), 64'd0);
        chk({tag, "_rsp_err"},   64'(io.rsp_err), 64'd0);
        chk({tag, "_rsp_rdata"}, io.rsp_rdata, 64'd0);
        chk({tag, "_ctl"},       64'(io.coprocessorIOControl), 64'd0);
        chk({tag, "_addr"},      64'(io.coprocessorIOAddr), 64'd0);
        chk({tag, "_dout"},      io.coprocessorIODataOut, 64'd0);
    endtask

    // Called just after a negedge with the DUT idle; returns just after the
    // negedge following the response handshake.
    task automatic run_cmd(input vec_t v);
        int last;
        last = v.exp_rsp + v.stall;
        io.cmd_valid = 1'b1;
        io.cmd_op    = v.op;
        io.cmd_addr  = v.addr;
        io.cmd_wdata = v.wdata;
        io.mem_busy  = 1'($urandom_range(0, 1));
        io.coprocessorIODataIn = rnd64();
        io.rsp_ready = 1'($urandom_range(0, 1));
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            chk("cmd_ready_busy", 64'(io.cmd_ready), 64'd0);
            chk("halt", 64'(io.coprocessorIOControl[4]), 64'(v.exp_halt));
            if (c == v.exp_acc) begin
                chk("acc_ctl",  64'(io.coprocessorIOControl), 64'(v.exp_ctl));
                chk("acc_addr", 64'(io.coprocessorIOAddr), 64'(v.exp_addr));
                chk("acc_dout", io.coprocessorIODataOut, v.exp_dout);
            end else begin
                chk("quiet_ctl",  64'(io.coprocessorIOControl[3:0]), 64'd0);
                chk("quiet_addr", 64'(io.coprocessorIOAddr), 64'd0);
                chk("quiet_dout", io.coprocessorIODataOut, 64'd0);
            end
            chk("rsp_valid", 64'(io.rsp_valid), 64'(c >= v.exp_rsp));
            if (c >= v.exp_rsp) begin
                chk("rsp_err",   64'(io.rsp_err), 64'(v.exp_err));
                chk("rsp_rdata", io.rsp_rdata, v.exp_rdata);
            end
            // Junk commands while busy must be ignored.
            io.cmd_valid = 1'($urandom_range(0, 1));
            io.cmd_op    = 2'($urandom_range(0, 3));
            io.cmd_addr  = 15'($urandom);
            io.cmd_wdata = rnd64();
            io.mem_busy  = (c <= v.busy_n) ? 1'b1 :
                           (c == v.busy_n + 1) ? 1'b0 : 1'($urandom_range(0, 1));
            io.coprocessorIODataIn = (c == v.exp_acc) ? v.datain : rnd64();
            io.rsp_ready = (c < v.exp_rsp) ? 1'($urandom_range(0, 1)) : (c == last);
        end
        @(negedge clk);
        io.rsp_ready = 1'b0;
        io.cmd_valid = 1'b0;
        io.mem_busy  = 1'($urandom_range(0, 1));
        chk_idle("post");
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [14:0] r_addr;

        io.cmd_valid = 1'b0; io.cmd_op = 2'd0; io.cmd_addr = 15'd0;
        io.cmd_wdata = 64'd0; io.rsp_ready = 1'b0; io.mem_busy = 1'b0;
        io.coprocessorIODataIn = 64'd0;

        // Directed table (TIMEOUT = 4).
        vecs.push_back(mk(2'd1, 15'd5, 64'hDEAD_BEEF, 0, 64'h55, 0,
                          1'b0, 64'd0, 3, 2, 5'b10001, 15'd5, 64'hDEAD_BEEF, 1'b1));
        vecs.push_back(mk(2'd0, 15'd7, 64'hFFFF, 0, 64'h1234_5678_9ABC_DEF0, 2,
                          1'b0, 64'h1234_5678_9ABC_DEF0, 3, 2, 5'b10010, 15'd7, 64'd0, 1'b1));
        vecs.push_back(mk(2'd0, 15'd31, 64'd0, 3, 64'hCAFE, 1,
                          1'b0, 64'hCAFE, 6, 5, 5'b10010, 15'd31, 64'd0, 1'b1));
        vecs.push_back(mk(2'd1, 15'd1, 64'h77, 99, 64'h0, 0,
                          1'b1, 64'd0, 5, 0, 5'd0, 15'd0, 64'd0, 1'b1));
        vecs.push_back(mk(2'd0, 15'h40, 64'd0, 0, 64'h9, 0,
                          1'b1, 64'd0, 1, 0, 5'd0, 15'd0, 64'd0, 1'b0));
        vecs.push_back(mk(2'd1, 15'd0, 64'd1, 1, 64'h0, 0,
                          1'b0, 64'd0, 4, 3, 5'b10001, 15'd0, 64'd1, 1'b1));
        vecs.push_back(mk(2'd1, 15'h7FE0, 64'd3, 0, 64'h0, 1,
                          1'b1, 64'd0, 1, 0, 5'd0, 15'd0, 64'd0, 1'b0));
        vecs.push_back(mk(2'd0, 15'd2, 64'd0, 4, 64'h1, 0,
                          1'b1, 64'd0, 5, 0, 5'd0, 15'd0, 64'd0, 1'b1));
`ifdef DEBUG_IO_CSR_EN
        vecs.push_back(mk(2'd2, 15'h300, 64'd0, 0, 64'h1800, 0,
                          1'b0, 64'h1800, 3, 2, 5'b11010, 15'h300, 64'd0, 1'b1));
        vecs.push_back(mk(2'd3, 15'hFFF, 64'hA5, 2, 64'h0, 1,
                          1'b0, 64'd0, 5, 4, 5'b11001, 15'hFFF, 64'hA5, 1'b1));
        vecs.push_back(mk(2'd2, 15'h1000, 64'd0, 0, 64'h0, 0,
                          1'b1, 64'd0, 1, 0, 5'd0, 15'd0, 64'd0, 1'b0));
`else
        vecs.push_back(mk(2'd2, 15'h300, 64'd0, 0, 64'h1800, 0,
                          1'b1, 64'd0, 1, 0, 5'd0, 15'd0, 64'd0, 1'b0));
        vecs.push_back(mk(2'd3, 15'h5, 64'hA5, 0, 64'h0, 1,
                          1'b1, 64'd0, 1, 0, 5'd0, 15'd0, 64'd0, 1'b0));
`endif

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("after_reset");

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Reset while halted with memory busy; the next command needs a cleared counter.
        io.cmd_valid = 1'b1; io.cmd_op = 2'd1; io.cmd_addr = 15'd3;
        io.cmd_wdata = 64'h33; io.mem_busy = 1'b1;
        @(negedge clk);
        io.cmd_valid = 1'b0;
        chk("rst_halt_pre", 64'(io.coprocessorIOControl), 64'h10);
        @(negedge clk);
        chk("rst_halt_pre2", 64'(io.coprocessorIOControl), 64'h10);
        reset = 1'b0;
        #1;
        chk_idle("rst_in_halt");
        @(negedge clk);
        reset = 1'b1;
        io.mem_busy = 1'b0;
        run_cmd(ref_model(2'd1, 15'd9, 64'h1234, TO - 1, 64'h0, 0));

        // Reset while holding a read response.
        io.cmd_valid = 1'b1; io.cmd_op = 2'd0; io.cmd_addr = 15'd9;
        io.mem_busy = 1'b0; io.coprocessorIODataIn = 64'hABCD;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            io.cmd_valid = 1'b0;
        end
        chk("rst_resp_valid", 64'(io.rsp_valid), 64'd1);
        chk("rst_resp_rdata", io.rsp_rdata, 64'hABCD);
        chk("rst_resp_halt", 64'(io.coprocessorIOControl), 64'h10);
        reset = 1'b0;
        #1;
        chk_idle("rst_in_resp");
        @(negedge clk);
        reset = 1'b1;
        run_cmd(ref_model(2'd0, 15'd17, 64'h0, 0, 64'h5A5A_0F0F, 1));

        // Random commands against the model.
        for (int k = 0; k < 200; k++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       r_addr = 15'($urandom_range(0, 31));
                1:       r_addr = 15'($urandom_range(0, 4095));
                2:       r_addr = 15'($urandom);
                default: r_addr = 15'($urandom_range(0, 31)) | (15'd1 << $urandom_range(5, 14));
            endcase
            run_cmd(ref_model(r_op, r_addr, rnd64(), $urandom_range(0, 6),
                              rnd64(), $urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
